// File: rtl/audio_tone_gen.sv
// Multi-channel square/noise tone generator with per-channel length timers and a registered mixer.
// Registers are addressed as wr_addr = {channel[5:0], reg[1:0]}; channels at or above NUM_CH are ignored.
module audio_tone_gen #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 12,
  parameter int VOL_W  = 4,
  localparam int OUT_W = VOL_W + ((NUM_CH > 1) ? $clog2(NUM_CH) : 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              frame_tick,
  output logic [OUT_W-1:0]  audio_out,
  output logic [NUM_CH-1:0] ch_active
);

  logic [5:0]        wr_ch;
  logic [1:0]        wr_reg;
  logic [NUM_CH-1:0] ch_bit;
  logic [NUM_CH-1:0] ch_en;
  logic [VOL_W-1:0]  ch_vol [NUM_CH];
  logic [OUT_W-1:0]  mix_sum;
  logic              unused_wr;

  assign wr_ch     = wr_addr[7:2];
  assign wr_reg    = wr_addr[1:0];
  assign unused_wr = ^wr_data;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] counter;
    logic [DIV_W-1:0] new_period;
    logic [VOL_W-1:0] vol;
    logic             en;
    logic             noise;
    logic             phase;
    logic [7:0]       length;
    logic [14:0]      lfsr;
    logic             hit;
    logic             running;
    logic             len_tick;

    assign hit        = wr_en && (wr_ch == 6'(i));
    assign running    = en && (period != '0);
    assign new_period = {wr_data[DIV_W-9:0], period[7:0]};
    // A same-cycle length write replaces the timer, so the tick must not also expire it.
    assign len_tick   = frame_tick && en && (length != 8'd0) && !(hit && (wr_reg == 2'd3));

    always_ff @(posedge clk) begin
      if (rst) begin
        period  <= '0;
        counter <= '0;
        vol     <= '0;
        en      <= 1'b0;
        noise   <= 1'b0;
        phase   <= 1'b0;
        length  <= 8'd0;
        lfsr    <= 15'h0001;
      end else begin
        if (running) begin
          if (counter == '0) begin
            counter <= period;
            phase   <= ~phase;
            lfsr    <= {lfsr[0] ^ lfsr[1], lfsr[14:1]};
          end else begin
            counter <= counter - DIV_W'(1);
          end
        end
        if (len_tick) begin
          length <= length - 8'd1;
          if (length == 8'd1) en <= 1'b0;
        end
        // Register writes come last so they override reload and length expiry.
        if (hit) begin
          case (wr_reg)
            2'd0: period[7:0] <= wr_data;
            2'd1: begin
              period  <= new_period;
              counter <= new_period;
              phase   <= 1'b0;
            end
            2'd2: begin
              vol   <= wr_data[VOL_W-1:0];
              en    <= wr_data[4];
              noise <= wr_data[5];
              if (!noise && wr_data[5]) lfsr <= 15'h0001;
            end
            default: length <= wr_data;
          endcase
        end
      end
    end

    assign ch_bit[i] = running && (noise ? lfsr[0] : phase);
    assign ch_en[i]  = en;
    assign ch_vol[i] = vol;
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_bit[i]) mix_sum = mix_sum + OUT_W'(ch_vol[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      audio_out <= '0;
      ch_active <= '0;
    end else begin
      audio_out <= mix_sum;
      ch_active <= ch_en;
    end
  end

endmodule

// File: doc/audio_tone_gen.md
AUDIO_TONE_GEN -- requirements
Module: audio_tone_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of tone channels, 1..16.
REQ-002 Parameter DIV_W, default 12: period divider width, 9..16.
REQ-003 Parameter VOL_W, default 4: per-channel volume width, 1..4.
REQ-004 Derived OUT_W = VOL_W + clog2(NUM_CH) (min VOL_W+1); mixer sum never overflows.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  register write strobe, one write per asserted cycle.
REQ-008 wr_addr  input  8  register address, channel = wr_addr[7:2], reg = wr_addr[1:0].
REQ-009 wr_data  input  8  register write data.
REQ-010 frame_tick  input  1  one-cycle strobe clocking the length counters.
REQ-011 audio_out  output  OUT_W  registered mixed sample.
REQ-012 ch_active  output  NUM_CH  registered per-channel enable bits.

Function
REQ-013 Per-channel regs: +0 period[7:0]; +1 period[DIV_W-1:8] (excess bits ignored); +2 ctrl = {-, -, noise(5), en(4), vol[3:0]} with vol truncated to VOL_W; +3 length[7:0].
REQ-014 Writes with channel index >= NUM_CH ignored, no state change.
REQ-015 Each channel: DIV_W-bit down-counter, 1-bit phase, 15-bit LFSR.
REQ-016 Counter runs only when en=1 and period!=0; else counter frozen, channel output 0.
REQ-017 Running, counter!=0: decrement by 1 per clk.
REQ-018 Running, counter==0: reload period, toggle phase, step LFSR; half-period = period+1 clks.
REQ-019 LFSR step: fb = lfsr[0]^lfsr[1]; lfsr = {fb, lfsr[14:1]}; never all-zero.
REQ-020 Channel output bit = phase when noise=0, lfsr[0] when noise=1.
REQ-021 Write to +1 (retrigger): period high stored, counter <= new full period, phase <= 0; wins over a same-cycle reload.
REQ-022 Write to +0 updates period register only; takes effect at next reload.
REQ-023 Write to +2 with noise bit 0->1 transition: lfsr <= 15'h0001.
REQ-024 Length 0: no timeout. Length nonzero: decrement on each frame_tick while en=1; on 1->0 transition, en <= 0 same edge.
REQ-025 Same-cycle write to +3 and frame_tick on that channel: write wins, no decrement.
REQ-026 Same-cycle write to +2 and length expiry: written en value wins.
REQ-027 audio_out <= sum over channels of (output bit ? vol : 0), unsigned, latency 1 clk from channel state.
REQ-028 ch_active <= en bits, latency 1 clk from en change.

Reset
REQ-029 On rst=1 at clk edge: all period, ctrl, length, counter, phase clear to 0; every lfsr <= 15'h0001; audio_out <= 0; ch_active <= 0.
REQ-030 rst overrides same-cycle wr_en and frame_tick; a tone mid-play stops, output 0 the following cycle.
REQ-031 After reset, no output until a channel is written with en=1 and period!=0.

Verification (NUM_CH=4, DIV_W=12, VOL_W=4, OUT_W=6)
REQ-032 Square: write ch0 +0=0x03, +1=0x00, +2=0x1F -> audio_out alternates 0 and 15 every 4 clks; ch_active=4'b0001.
REQ-033 Mix: add ch1 +0=0x03, +1=0x00, +2=0x1A -> audio_out steps among {0,10,15,25}; both in phase after retriggers in same frame -> values 0/25.
REQ-034 Length: ch0 +3=0x02, two frame_ticks -> en cleared on second tick edge; ch_active[0]=0 and ch0 contribution 0 one clk later; further ticks no effect.
REQ-035 Noise: ch2 +0=0x00, +1=0x00 period 0 -> output 0; then +0=0x01, +2=0x38 -> lfsr from 0x0001, audio_out contribution follows lfsr[0] stepping every 2 clks (first values 8,0,0,...).
REQ-036 Boundaries: write to addr 0x10 (channel 4) -> no change; retrigger on reload cycle -> phase 0, counter = new period; rst mid-play -> audio_out=0, ch_active=0 next clk.
